gpio_capture_monitor: RTL
=========================

GPIO_CAPTURE_MONITOR -- requirements
Module: gpio_capture_monitor

Interface
REQ-001 Parameter WIDTH, default 32, meaning gpio bus width (1..64).
REQ-002 Parameter DEPTH, default 8, meaning capture FIFO entries (power of 2, 2..64).
REQ-003 Parameter SETTLE_CYC, default 4, meaning clk cycles from ext-edge sample to record push (1..15).
REQ-004 One clock; reset is asynchronous and active-high; ports: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-005 gpio  input  WIDTH  monitored bus, sampled on clk.
REQ-006 ext_clk  input  1  asynchronous external strobe.
REQ-007 enable  input  1  capture enable.
REQ-008 mode  input  1  0 = CHANGE, 1 = EXT_EDGE; latched on enable rising edge.
REQ-009 mask  input  WIDTH  per-bit change-detect mask, 1 = compared.
REQ-010 clr  input  1  synchronous flush of FIFO and sticky flags.
REQ-011 evt_valid / evt_ready  output / input  1 / 1  record handshake.
REQ-012 evt_gpio  output  WIDTH  captured bus value.
REQ-013 evt_ext_clk  output  1  ext_clk level of the edge recorded; 0 in CHANGE mode.
REQ-014 overflow  output  1  sticky: record dropped because FIFO full.
REQ-015 missed  output  1  sticky: ext edge dropped during SETTLE.
REQ-016 level  output  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-017 ext_clk SHALL pass a 2-flop synchronizer; edge detect compares stage 2 with a third flop.
REQ-018 CHANGE mode: first clk with enable high SHALL load last_sample = gpio with no push.
REQ-019 CHANGE mode: push SHALL occur when (gpio & mask) != (last_sample & mask); last_sample updates to full gpio on every push.
REQ-020 CHANGE latency: gpio change sampled at edge N SHALL give evt_valid high after edge N+1 (FIFO empty, evt_ready irrelevant).
REQ-021 EXT_EDGE FSM SHALL have states IDLE, SETTLE, PUSH.
REQ-022 IDLE: synced edge detected -> capture gpio and edge polarity on next clk, load counter = SETTLE_CYC, go to SETTLE.
REQ-023 SETTLE: decrement each clk; at 0 go to PUSH; any further synced edge SHALL be dropped and set missed.
REQ-024 PUSH: write record for one cycle, return to IDLE.
REQ-025 FIFO SHALL be first-word-fall-through; pop when evt_valid && evt_ready.
REQ-026 Write SHALL be accepted when level < DEPTH, or level == DEPTH with same-cycle pop; otherwise record dropped and overflow set.
REQ-027 Simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-028 enable low SHALL stop new captures, return FSM to IDLE and abandon any in-flight SETTLE record; FIFO contents remain poppable.
REQ-029 clr SHALL empty FIFO, clear overflow and missed, return FSM to IDLE; clr has priority over push and pop in the same cycle.
REQ-030 mode changes while enable is high SHALL be ignored.

Reset
REQ-031 rst SHALL asynchronously force evt_valid=0, evt_gpio=0, evt_ext_clk=0, overflow=0, missed=0, level=0, FSM=IDLE, last_sample=0, synchronizer flops=0, latched mode=CHANGE.
REQ-032 rst asserted mid-SETTLE or with FIFO non-empty SHALL discard all pending records.

Configuration
REQ-033 With GPIO_CAPTURE_TIMESTAMP_EN defined: 16-bit free-running counter (reset 0, wraps 0xFFFF->0) stored per record at capture time; output port evt_ts [15:0].
REQ-034 Without GPIO_CAPTURE_TIMESTAMP_EN: no counter, no evt_ts port, FIFO width WIDTH+1.

Structure
REQ-035 Package gpio_capture_pkg SHALL hold the mode enum, FSM state enum and timestamp width constant.
REQ-036 FIFO SHALL be sub-module gpio_capture_fifo (parameters WIDTH, DEPTH) with level, full and empty outputs.

Verification
REQ-037 CHANGE, mask=0xFFFF_FFFF, gpio 0x0->0x5 at cycle 10 -> one record evt_gpio=0x5, evt_valid high at cycle 12.
REQ-038 CHANGE, mask=0x0000_00FF, gpio toggles bit 16 only -> no record; then bit 0 toggles -> one record.
REQ-039 EXT_EDGE, SETTLE_CYC=4, one ext_clk pulse -> two records, evt_ext_clk=1 then 0; extra edge inside SETTLE -> missed=1.
REQ-040 DEPTH=4, evt_ready=0, 6 changes -> level=4, overflow=1, first 4 values poppable in order; clr -> level=0, overflow=0.
REQ-041 FIFO full with push and pop same cycle -> level stays 4, overflow stays 0.
REQ-042 rst asserted during SETTLE with 2 records queued -> evt_valid=0, level=0 immediately; no record after release.

Source files
------------

// File: rtl/gpio_capture_pkg.sv
// Shared types for the GPIO capture monitor: capture mode, EXT_EDGE FSM states,
// timestamp width (used only when GPIO_CAPTURE_TIMESTAMP_EN is defined).
package gpio_capture_pkg;

  typedef enum logic {
    MODE_CHANGE   = 1'b0,
    MODE_EXT_EDGE = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PUSH   = 2'd2
  } state_t;

  localparam int TS_W = 16;

endpackage

// File: rtl/gpio_capture_fifo.sv
// First-word-fall-through record FIFO. Writes are accepted when not full, or when
// full and a pop happens in the same cycle. clr empties it and beats push and pop.
module gpio_capture_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // An empty FIFO presents zeros so downstream never sees stale data.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gpio_capture_monitor.sv
// GPIO capture monitor: records bus changes (CHANGE) or ext_clk edges (EXT_EDGE) into a FIFO.
// Optional per-record timestamps and evt_ts port when GPIO_CAPTURE_TIMESTAMP_EN is defined.
module gpio_capture_monitor
  import gpio_capture_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             gpio,
  input  logic                         ext_clk,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             mask,
  input  logic                         clr,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [WIDTH-1:0]             evt_gpio,
  output logic                         evt_ext_clk,
  output logic                         overflow,
  output logic                         missed,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]              evt_ts
`endif
);

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  localparam int REC_W = WIDTH + 1 + TS_W;
`else
  localparam int REC_W = WIDTH + 1;
`endif

  logic             sync_1;
  logic             sync_2;
  logic             sync_3;
  logic             ext_edge;
  logic             enable_q;
  logic             en_rise;
  mode_t            mode_r;
  mode_t            act_mode;
  logic [WIDTH-1:0] gpio_q;
  logic [WIDTH-1:0] last_sample;
  logic             primed;
  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] cap_gpio;
  logic             cap_pol;
  logic             chg_push;
  logic             ext_push;
  logic             push;
  logic             pop;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_cnt;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  cap_ts;
`endif

  assign ext_edge = sync_2 ^ sync_3;
  assign en_rise  = enable && !enable_q;
  // The mode input only matters on the clock where enable rises.
  assign act_mode = en_rise ? mode_t'(mode) : mode_r;
  assign chg_push = enable && (act_mode == MODE_CHANGE) && primed &&
                    (((gpio_q ^ last_sample) & mask) != '0);
  assign ext_push = enable && (state == ST_PUSH);
  assign pop      = evt_valid && evt_ready;

  // ext_clk synchronizer plus the third flop used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= ext_clk;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  // Mode latch, bus sample, and the CHANGE-mode reference value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q    <= 1'b0;
      mode_r      <= MODE_CHANGE;
      gpio_q      <= '0;
      last_sample <= '0;
      primed      <= 1'b0;
    end else begin
      enable_q <= enable;
      gpio_q   <= gpio;
      if (en_rise) mode_r <= mode_t'(mode);
      if (!enable || (act_mode != MODE_CHANGE)) begin
        primed <= 1'b0;
      end else if (!primed) begin
        last_sample <= gpio;
        primed      <= 1'b1;
      end else if (chg_push) begin
        last_sample <= gpio_q;
      end
    end
  end

  // EXT_EDGE capture FSM; edges arriving while a record is settling are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      cap_gpio   <= '0;
      cap_pol    <= 1'b0;
      missed     <= 1'b0;
    end else if (clr) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      missed     <= 1'b0;
    end else if (!enable || (act_mode != MODE_EXT_EDGE)) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ext_edge) begin
            cap_gpio   <= gpio;
            cap_pol    <= sync_2;
            settle_cnt <= 4'(SETTLE_CYC);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (ext_edge) missed <= 1'b1;
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) state <= ST_PUSH;
        end
        ST_PUSH: begin
          if (ext_edge) missed <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  // Free-running timestamp and the copies taken at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
      cap_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      ts_q   <= ts_cnt;
      if ((state == ST_IDLE) && ext_edge) cap_ts <= ts_cnt;
    end
  end
`endif

  // Record assembly: {timestamp (optional), ext_clk level, bus value}.
  always_comb begin
    push = 1'b0;
    rec  = '0;
    if (ext_push) begin
      push = 1'b1;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
      rec  = {cap_ts, cap_pol, cap_gpio};
`else
      rec  = {cap_pol, cap_gpio};
`endif
    end else if (chg_push) begin
      push = 1'b1;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
      rec  = {ts_q, 1'b0, gpio_q};
`else
      rec  = {1'b0, gpio_q};
`endif
    end else begin
      push = 1'b0;
      rec  = '0;
    end
  end

  // Sticky overflow: a record arrived with the FIFO full and nothing leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  gpio_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (push),
    .wr_data (rec),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid   = !fifo_empty;
  assign evt_gpio    = head[WIDTH-1:0];
  assign evt_ext_clk = head[WIDTH];
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  assign evt_ts      = head[REC_W-1 -: TS_W];
`endif

endmodule
